proc_core: RTL
==============

PROC_CORE -- requirements
Module: proc_core

Interface
REQ-001 SHALL have parameter DW, default 16, meaning register and ALU data width (legal range 8..32).
REQ-002 SHALL have parameter AW, default 8, meaning program counter and instruction address width (legal range 4..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begin execution at address 0; honoured only in IDLE or HALTED.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction fetch request, registered.
REQ-007 SHALL have port imem_addr, output, AW bits: fetch address, equal to pc.
REQ-008 SHALL have port imem_ack, input, 1 bit: fetch accepted; imem_data is valid in the same cycle.
REQ-009 SHALL have port imem_data, input, 16 bits: instruction word.
REQ-010 SHALL have port pc, output, AW bits: current program counter.
REQ-011 SHALL have port busy, output, 1 bit: high in FETCH, DECODE and EXEC.
REQ-012 SHALL have port halted, output, 1 bit: high in HALTED.
REQ-013 SHALL have port flags, output, 3 bits: {C,N,Z}.
REQ-014 SHALL have port dbg_sel, input, 3 bits, and port dbg_data, output, DW bits: combinational read of register dbg_sel.
REQ-015 SHALL have port retired, output, 16 bits: retired-instruction count (see Configuration).

Function
REQ-016 SHALL use instruction fields cond[15:14], op[13:10], rd[9:7], rs1[6:4], rs2[3:1], imm7[6:0], sh4[3:0].
REQ-017 SHALL implement the FSM IDLE->FETCH on start; FETCH->DECODE on imem_ack; DECODE->EXEC; EXEC->FETCH, or EXEC->HALTED on an executed HALT.
REQ-018 SHALL assert imem_req throughout FETCH, deassert it in the cycle after ack, and latch imem_data on ack; any number of wait cycles is legal.
REQ-019 SHALL retire one instruction per 3 cycles under zero-wait ack.
REQ-020 SHALL evaluate cond in EXEC against the flags: 00 always, 01 Z=1, 10 N=1, 11 C=1; a failed instruction SHALL only advance pc by 1.
REQ-021 SHALL decode op codes 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6 NOT rs1; 7 MOV rs1; 8 SHL rs1 by sh4; 9 SHR (logical) rs1 by sh4; 10 LDI rd<=zero-extended imm7; 11 JMP pc<=imm7 (zero-extended or truncated to AW); 12 CMP (flags of rs1-rs2, no write); 13 HALT; 14-15 treated as NOP.
REQ-022 SHALL write rd and update flags at the end of EXEC for ops 1-9; LDI SHALL write rd without changing flags; NOP, JMP and HALT SHALL leave the flags unchanged.
REQ-023 SHALL compute all arithmetic modulo 2^DW: ADD C = carry-out; SUB/CMP C = 1 when rs1>=rs2 (unsigned); logic ops and shifts C = 0; N = result MSB; Z = (result==0).
REQ-024 SHALL give shifts with sh4>=DW a zero result.
REQ-025 SHALL advance pc by 1 modulo 2^AW, so pc wraps from 2^AW-1 to 0.
REQ-026 SHALL read the source register value before the write when rd equals rs1 or rs2 (read-before-write within EXEC).
REQ-027 SHALL ignore start while busy; start in HALTED SHALL restart at pc=0 with registers and flags retained.

Reset
REQ-028 SHALL, on rst at a clock edge, set state=IDLE, pc=0, imem_req=0, flags=0, all registers=0 and retired=0.
REQ-029 SHALL give rst priority over start and imem_ack in the same cycle; rst during FETCH SHALL drop imem_req in the following cycle and discard any ack.

Configuration
REQ-030 SHALL, when PROC_CORE_RETIRE_CNT_EN is defined, increment retired by 1 for every EXEC whose cond passes (HALT included), saturating at 16'hFFFF.
REQ-031 SHALL, when PROC_CORE_RETIRE_CNT_EN is undefined, hold retired constant 0 and build no counter logic.

Verification
REQ-032 SHALL cover: rst, start, zero-wait program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT -> r3=8, flags=000, halted after 12 cycles, retired=4 with the macro defined.
REQ-033 SHALL cover: DW=8, LDI r1,127; ADD r1,r1,r1 twice -> r1=8'hFC, C=1, N=1 after the second ADD.
REQ-034 SHALL cover: CMP r1,r1 then cond=01 JMP 0x10 -> pc=0x10; cond=10 JMP after it is skipped with pc+1.
REQ-035 SHALL cover: imem_ack delayed 4 cycles -> imem_req held for 5 cycles, the instruction is latched once, and pc is unchanged until EXEC.
REQ-036 SHALL cover: AW=4, 16 NOPs -> pc wraps 15->0; rst asserted mid-FETCH -> imem_req=0, pc=0 and IDLE on the next cycle.

Source files
------------

// File: rtl/proc_core.sv
// Small multi-cycle accumulator-free register machine: FETCH/DECODE/EXEC over an 8-entry register file.
// Define PROC_CORE_RETIRE_CNT_EN to build the saturating retired-instruction counter.
module proc_core #(
   parameter int DW = 16,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [15:0]   imem_data,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic [2:0]    flags,
   input  logic [2:0]    dbg_sel,
   output logic [DW-1:0] dbg_data,
   output logic [15:0]   retired
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_MOV  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_LDI  = 4'd10;
   localparam logic [3:0] OP_JMP  = 4'd11;
   localparam logic [3:0] OP_CMP  = 4'd12;
   localparam logic [3:0] OP_HALT = 4'd13;

   logic [2:0]    state;
   logic [15:0]   ir;
   logic [DW-1:0] regs [8];

   logic [1:0]    cond;
   logic [3:0]    op;
   logic [2:0]    rd;
   logic [2:0]    rs1;
   logic [2:0]    rs2;
   logic [6:0]    imm7;
   logic [3:0]    sh4;

   logic [DW-1:0] src_a;
   logic [DW-1:0] src_b;
   logic [DW:0]   sum;
   logic [DW-1:0] result;
   logic          carry;
   logic          wr_en;
   logic          flag_en;
   logic          cond_pass;
   logic          shift_out;
   logic [AW-1:0] pc_next;
   logic [AW-1:0] jmp_target;

   assign cond = ir[15:14];
   assign op   = ir[13:10];
   assign rd   = ir[9:7];
   assign rs1  = ir[6:4];
   assign rs2  = ir[3:1];
   assign imm7 = ir[6:0];
   assign sh4  = ir[3:0];

   assign imem_addr = pc;
   assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
   assign halted    = (state == S_HALTED);
   assign dbg_data  = regs[dbg_sel];

   assign src_a      = regs[rs1];
   assign src_b      = regs[rs2];
   assign sum        = {1'b0, src_a} + {1'b0, src_b};
   assign shift_out  = (32'(sh4) >= DW);
   assign pc_next    = pc + AW'(1);
   assign jmp_target = AW'(imm7);

   always_comb begin
      case (cond)
         2'd0:    cond_pass = 1'b1;
         2'd1:    cond_pass = flags[0];
         2'd2:    cond_pass = flags[1];
         default: cond_pass = flags[2];
      endcase
   end

   // Operands are read from the register file before the end-of-EXEC write, so rd==rs is safe.
   always_comb begin
      result  = '0;
      carry   = 1'b0;
      wr_en   = 1'b0;
      flag_en = 1'b0;
      case (op)
         OP_ADD: begin result = sum[DW-1:0]; carry = sum[DW]; wr_en = 1'b1; flag_en = 1'b1; end
         OP_SUB: begin result = src_a - src_b; carry = (src_a >= src_b); wr_en = 1'b1; flag_en = 1'b1; end
         OP_AND: begin result = src_a & src_b; wr_en = 1'b1; flag_en = 1'b1; end
         OP_OR:  begin result = src_a | src_b; wr_en = 1'b1; flag_en = 1'b1; end
         OP_XOR: begin result = src_a ^ src_b; wr_en = 1'b1; flag_en = 1'b1; end
         OP_NOT: begin result = ~src_a; wr_en = 1'b1; flag_en = 1'b1; end
         OP_MOV: begin result = src_a; wr_en = 1'b1; flag_en = 1'b1; end
         OP_SHL: begin result = shift_out ? '0 : (src_a << sh4); wr_en = 1'b1; flag_en = 1'b1; end
         OP_SHR: begin result = shift_out ? '0 : (src_a >> sh4); wr_en = 1'b1; flag_en = 1'b1; end
         OP_LDI: begin result = DW'(imm7); wr_en = 1'b1; end
         OP_CMP: begin result = src_a - src_b; carry = (src_a >= src_b); flag_en = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= '0;
         imem_req <= 1'b0;
         flags    <= '0;
         ir       <= '0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  state    <= S_FETCH;
                  pc       <= '0;
                  imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  ir       <= imem_data;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: state <= S_EXEC;
            S_EXEC: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
               pc       <= pc_next;
               if (cond_pass) begin
                  if (wr_en) regs[rd] <= result;
                  if (flag_en) flags <= {carry, result[DW-1], (result == '0)};
                  if (op == OP_JMP) pc <= jmp_target;
                  if (op == OP_HALT) begin
                     state    <= S_HALTED;
                     imem_req <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef PROC_CORE_RETIRE_CNT_EN
   logic [15:0] retire_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt <= '0;
      end else if ((state == S_EXEC) && cond_pass && (retire_cnt != 16'hFFFF)) begin
         retire_cnt <= retire_cnt + 16'd1;
      end
   end

   assign retired = retire_cnt;
`else
   assign retired = 16'h0000;
`endif

endmodule
